axi_sram_slave: RTL

- AXI3/AXI4-compatible memory responder (slave). It is the far end of the 32-bit AXI master port that the CPU top exports.
- Used as the simulation and FPGA backing store for unit-level CPU, cache and AXI-arbiter benches.
- Supports one outstanding read burst and one outstanding write burst, serviced concurrently by independent read and write FSMs over a byte-writable word array.

---
 rtl/axi_sram_slave_if.sv | 70 +++++++
 rtl/axi_sram_slave.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI3/AXI4 bus bundle between a 32-bit master and the SRAM responder.
// Clock and reset stay outside so one bundle can cross clock-agnostic hierarchy.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI memory responder: one read burst and one write burst in flight at a time,
// serviced by independent FSMs over a byte-writable 32-bit word array.
module axi_sram_slave #(
    parameter int    MEM_AW    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_sram_slave_if.slave  bus
);

    localparam int         DEPTH       = 1 << (MEM_AW - 2);
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // NOTE: the array has no reset; clearing it would stop it mapping onto block RAM.
    logic [31:0] mem [DEPTH];

    // WRAP deliberately advances like INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
    endfunction

    // ---------------- read channel ----------------
    r_state_e    r_state, r_state_nx;
    logic        ar_fire, r_fire;
    logic [3:0]  r_id;
    logic [31:0] r_addr, r_addr_nx, r_data;
    logic [7:0]  r_len, r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_last;

    assign r_addr_nx = next_addr(r_addr, r_size, r_burst);

    // NOTE: state and datapath registers use <= so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx  = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        ar_fire     = 1'b0;
        r_fire      = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                bus.arready = aresetn;
                ar_fire     = bus.arvalid && aresetn;
                if (ar_fire) r_state_nx = R_DATA;
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                r_fire     = bus.rready;
                if (r_fire && r_last) r_state_nx = R_IDLE;
            end
        endcase
    end

    // The fetch reads mem before this edge's write lands, so a same-word
    // collision returns the old value.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (ar_fire) begin
            r_id    <= bus.arid;
            r_addr  <= bus.araddr;
            r_len   <= bus.arlen;
            r_cnt   <= '0;
            r_size  <= bus.arsize;
            r_burst <= bus.arburst;
            r_data  <= mem[bus.araddr[MEM_AW-1:2]];
            r_last  <= (bus.arlen == 8'd0);
        end else if (r_fire) begin
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= r_addr_nx;
                r_data <= mem[r_addr_nx[MEM_AW-1:2]];
                r_last <= (r_cnt + 8'd1 == r_len);
            end
        end
    end

    assign bus.rid   = r_id;
    assign bus.rdata = r_data;
    assign bus.rlast = r_last;
    assign bus.rresp = 2'b00;

    // ---------------- write channel ----------------
    w_state_e    w_state, w_state_nx;
    logic        aw_fire, w_fire;
    logic [3:0]  w_id;
    logic [31:0] w_addr;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;

    always_ff @(posedge aclk) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        aw_fire     = 1'b0;
        w_fire      = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                bus.awready = aresetn;
                aw_fire     = bus.awvalid && aresetn;
                if (aw_fire) w_state_nx = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                w_fire     = bus.wvalid && aresetn;
                if (w_fire && bus.wlast) w_state_nx = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_size  <= '0;
            w_burst <= '0;
        end else if (aw_fire) begin
            w_id    <= bus.awid;
            w_addr  <= bus.awaddr;
            w_size  <= bus.awsize;
            w_burst <= bus.awburst;
        end else if (w_fire) begin
            w_addr  <= next_addr(w_addr, w_size, w_burst);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[w_addr[MEM_AW-1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.bid   = w_id;
    assign bus.bresp = 2'b00;

    // Burst end is taken from wlast; awlen and the sideband attributes are not needed.
    logic unused_inputs;
    assign unused_inputs = ^{bus.wid, bus.awlen, bus.arlock, bus.arcache, bus.arprot,
                             bus.awlock, bus.awcache, bus.awprot};

endmodule
